// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Fractional baud-rate tick generator with 16x/8x oversampling,
//            mid-bit sample tick, bit tick and receiver resynchronisation.
// Revision : 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int SYS_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int DVSR_W    = 16,
    parameter int FRAC_W    = 4,
    parameter int RST_INT   = SYS_FREQ / (16 * BAUD_RATE),
    parameter int RST_FRAC  = ((SYS_FREQ % (16 * BAUD_RATE)) * (2 ** FRAC_W)
                               + 8 * BAUD_RATE) / (16 * BAUD_RATE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [DVSR_W-1:0] cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_osr8,
    output logic              cfg_err,
    output logic              cfg_pending,
    output logic              tick,
    output logic              sample_tick,
    output logic              bit_tick
);

    localparam logic [DVSR_W-1:0] c_rst_int  = DVSR_W'(RST_INT);
    localparam logic [FRAC_W-1:0] c_rst_frac = FRAC_W'(RST_FRAC);
    localparam logic [DVSR_W:0]   c_one      = (DVSR_W+1)'(1);
    localparam logic [DVSR_W:0]   c_rst_cnt  = {1'b0, c_rst_int} - c_one;
    localparam logic [DVSR_W-1:0] c_min_int  = DVSR_W'(2);

    // Active configuration and counters
    logic [DVSR_W-1:0] r_int;
    logic [FRAC_W-1:0] r_frac;
    logic              r_osr8;
    logic [DVSR_W:0]   r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [3:0]        r_os;

    // Shadow configuration
    logic [DVSR_W-1:0] r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_sh_osr8;
    logic              r_pend;

    logic              r_tick;
    logic              r_sample_tick;
    logic              r_bit_tick;
    logic              r_cfg_err;

    logic              w_reload;
    logic              w_apply;
    logic              w_cfg_ok;
    logic [FRAC_W:0]   w_sum;
    logic              w_carry;
    logic [3:0]        w_os_next;
    logic [3:0]        w_os_half;
    logic [3:0]        w_os_last;
    logic [DVSR_W-1:0] w_resync_int;

    assign w_reload     = enable && (r_cnt == '0);
    assign w_apply      = r_pend && (w_reload || !enable);
    assign w_cfg_ok     = (cfg_int >= c_min_int);
    assign w_sum        = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_carry      = w_sum[FRAC_W];
    assign w_os_next    = r_osr8 ? {1'b0, r_os[2:0] + 3'd1} : r_os + 4'd1;
    assign w_os_half    = r_osr8 ? 4'd3 : 4'd7;
    assign w_os_last    = r_osr8 ? 4'd7 : 4'd15;
    assign w_resync_int = r_pend ? r_sh_int : r_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int         <= c_rst_int;
            r_frac        <= c_rst_frac;
            r_osr8        <= 1'b0;
            r_cnt         <= c_rst_cnt;
            r_acc         <= '0;
            r_os          <= '0;
            r_tick        <= 1'b0;
            r_sample_tick <= 1'b0;
            r_bit_tick    <= 1'b0;
        end else begin
            r_tick        <= 1'b0;
            r_sample_tick <= 1'b0;
            r_bit_tick    <= 1'b0;
            if (sync_clr) begin
                // Resync never ticks, even when it lands on a reload edge
                if (r_pend) begin
                    r_int  <= r_sh_int;
                    r_frac <= r_sh_frac;
                    r_osr8 <= r_sh_osr8;
                end
                r_cnt <= {1'b0, w_resync_int} - c_one;
                r_acc <= '0;
                r_os  <= '0;
            end else if (w_apply) begin
                // The tick of the closing period still uses the old phase
                if (w_reload) begin
                    r_tick        <= 1'b1;
                    r_sample_tick <= (r_os == w_os_half);
                    r_bit_tick    <= (r_os == w_os_last);
                end
                r_int  <= r_sh_int;
                r_frac <= r_sh_frac;
                r_osr8 <= r_sh_osr8;
                r_cnt  <= {1'b0, r_sh_int} - c_one;
                r_acc  <= '0;
                r_os   <= '0;
            end else if (w_reload) begin
                r_tick        <= 1'b1;
                r_sample_tick <= (r_os == w_os_half);
                r_bit_tick    <= (r_os == w_os_last);
                r_acc         <= w_sum[FRAC_W-1:0];
                r_cnt         <= {1'b0, r_int} - c_one + {{DVSR_W{1'b0}}, w_carry};
                r_os          <= w_os_next;
            end else if (enable) begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    // A write coinciding with an apply edge wins over the pend clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_int  <= c_rst_int;
            r_sh_frac <= c_rst_frac;
            r_sh_osr8 <= 1'b0;
            r_pend    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (cfg_we && w_cfg_ok) begin
                r_sh_int  <= cfg_int;
                r_sh_frac <= cfg_frac;
                r_sh_osr8 <= cfg_osr8;
                r_pend    <= 1'b1;
            end else if (sync_clr || w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign tick        = r_tick;
    assign sample_tick = r_sample_tick;
    assign bit_tick    = r_bit_tick;
    assign cfg_err     = r_cfg_err;
    assign cfg_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baud_gen
// Purpose  : Scoreboard bench for uart_baud_gen against a closed-form model.
// Revision : 1.0
// ============================================================================
module tb_uart_baud_gen;

    localparam int C_FRAC_ONE = 16;
    localparam int C_DEF_INT  = 651;
    localparam int C_DEF_FRAC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sync_clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_int = '0;
    logic [3:0]  cfg_frac = '0;
    logic        cfg_osr8 = 1'b0;
    logic        cfg_err;
    logic        cfg_pending;
    logic        tick;
    logic        sample_tick;
    logic        bit_tick;

    uart_baud_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sync_clr    (sync_clr),
        .cfg_we      (cfg_we),
        .cfg_int     (cfg_int),
        .cfg_frac    (cfg_frac),
        .cfg_osr8    (cfg_osr8),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .tick        (tick),
        .sample_tick (sample_tick),
        .bit_tick    (bit_tick)
    );

    always #5 clk = ~clk;

    int edge_no;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_no <= 0;
        else       edge_no <= edge_no + 1;
    end

    typedef struct {int e; logic s; logic b;} tick_t;
    typedef struct {int e; logic p;} pend_t;
    tick_t tq[$];
    pend_t pq[$];
    int    eq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Reference model: an epoch starts at reset, resync or config apply.
    // Counting enabled edges from the epoch start, tick n lands on edge
    // n*int + floor((n-1)*frac/16); its oversample index is (n-1) mod OSR.
    int m_int, m_frac, m_osr, m_a, m_n;
    int sh_int, sh_frac, sh_osr;
    bit m_pend;

    function automatic int tick_at(input int n);
        return n * m_int + ((n - 1) * m_frac) / C_FRAC_ONE;
    endfunction

    task automatic model_reset();
        m_int = C_DEF_INT; m_frac = C_DEF_FRAC; m_osr = 16;
        sh_int = C_DEF_INT; sh_frac = C_DEF_FRAC; sh_osr = 16;
        m_a = 0; m_n = 0; m_pend = 0;
    endtask

    task automatic model_apply();
        m_int = sh_int; m_frac = sh_frac; m_osr = sh_osr;
        m_a = 0; m_n = 0; m_pend = 0;
    endtask

    // Called at negedge+1: drives inputs for the coming edge and predicts it
    task automatic step(input bit en, input bit sc, input bit we,
                        input int ci, input int cf, input bit co);
        int    e;
        bit    rl;
        tick_t t;
        pend_t p;
        enable = en; sync_clr = sc; cfg_we = we;
        cfg_int = 16'(ci); cfg_frac = 4'(cf); cfg_osr8 = co;
        e = edge_no + 1;
        if (we && ci < 2) eq.push_back(e);
        if (sc) begin
            if (m_pend) model_apply();
            m_a = 0; m_n = 0; m_pend = 0;
        end else begin
            rl = en && (m_a + 1 == tick_at(m_n + 1));
            if (rl) begin
                m_n++;
                t.e = e;
                t.s = ((m_n % m_osr) == m_osr / 2);
                t.b = ((m_n % m_osr) == 0);
                tq.push_back(t);
            end
            if (en) m_a++;
            if (m_pend && (rl || !en)) model_apply();
        end
        if (we && ci >= 2) begin
            sh_int = ci; sh_frac = cf; sh_osr = co ? 8 : 16; m_pend = 1;
        end
        p.e = e; p.p = m_pend;
        pq.push_back(p);
        @(negedge clk); #1;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 0, 0, 0, 0, 0);
    endtask

    // Monitor: checks each presented output against the scoreboard queues
    initial begin
        tick_t t;
        pend_t p;
        int    x;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pq.size() > 0 && pq[0].e == edge_no) begin
                    p = pq.pop_front();
                    chk("cfg_pending", int'(cfg_pending), int'(p.p));
                end
                if (tick) begin
                    if (tq.size() > 0 && tq[0].e == edge_no) begin
                        t = tq.pop_front();
                        chk("sample_tick", int'(sample_tick), int'(t.s));
                        chk("bit_tick", int'(bit_tick), int'(t.b));
                    end else begin
                        chk("tick_unexpected", int'(tick), 0);
                    end
                end else begin
                    if (tq.size() > 0 && tq[0].e <= edge_no) begin
                        t = tq.pop_front();
                        chk("tick_missing", int'(tick), 1);
                    end
                    if (sample_tick || bit_tick)
                        chk("subtick_without_tick", int'(sample_tick | bit_tick), 0);
                end
                if (cfg_err) begin
                    if (eq.size() > 0 && eq[0] == edge_no) x = eq.pop_front();
                    else chk("cfg_err_unexpected", int'(cfg_err), 0);
                end else if (eq.size() > 0 && eq[0] <= edge_no) begin
                    x = eq.pop_front();
                    chk("cfg_err_missing", int'(cfg_err), 1);
                end
            end
        end
    end

    initial begin
        bit en, sc, we, co;
        int ci, cf, i;

        #3;
        chk("reset_tick", int'(tick), 0);
        chk("reset_sample_tick", int'(sample_tick), 0);
        chk("reset_bit_tick", int'(bit_tick), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        chk("reset_cfg_pending", int'(cfg_pending), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Default rate: 16+ periods of 651/652 cycles
        run(10500, 1);

        // Legal write mid-period: 4 + 8/16, 8x oversampling
        step(1, 0, 1, 4, 8, 1);
        run(200, 1);

        // Illegal writes are rejected
        step(1, 0, 1, 1, 3, 0);
        run(20, 1);
        step(1, 0, 1, 0, 5, 1);
        run(60, 1);

        // Enable gating with int 10
        step(1, 0, 1, 10, 0, 0);
        run(60, 1);
        run(4, 1);
        run(7, 0);
        run(60, 1);

        // Resync 3 cycles before an expected tick
        for (i = 0; i < 100 && (m_a + 3 != tick_at(m_n + 1)); i++) step(1, 0, 0, 0, 0, 0);
        chk("resync_lookahead", int'(m_a + 3 == tick_at(m_n + 1)), 1);
        step(1, 1, 0, 0, 0, 0);
        run(200, 1);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            en = ($urandom % 16) != 0;
            sc = ($urandom % 64) == 0;
            we = ($urandom % 40) == 0;
            ci = int'($urandom_range(12, 0));
            cf = int'($urandom_range(15, 0));
            co = 1'($urandom % 2);
            step(en, sc, we, ci, cf, co);
        end

        // Asynchronous reset while a tick and a pending config are live
        for (i = 0; i < 3000 && (m_a + 1 != tick_at(m_n + 1)); i++) step(1, 0, 0, 0, 0, 0);
        chk("reset_lookahead", int'(m_a + 1 == tick_at(m_n + 1)), 1);
        step(1, 0, 1, 5, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_tick", int'(tick), 0);
        chk("async_reset_sample_tick", int'(sample_tick), 0);
        chk("async_reset_bit_tick", int'(bit_tick), 0);
        chk("async_reset_cfg_pending", int'(cfg_pending), 0);
        tq.delete(); pq.delete(); eq.delete();
        model_reset();
        @(negedge clk); #1;
        reset = 1'b0;
        run(700, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable fractional baud-rate tick generator for the UART TX/RX datapaths. It supersedes the fixed-divisor tick generator and adds:
- a runtime-loadable integer and fractional divisor
- selectable 16x/8x oversampling
- a bit-rate tick and a mid-bit sample tick
- a resynchronisation input that the receiver uses on start-bit detection

## Interface
- SYS_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: baud rate in effect at reset.
- DVSR_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor, in units of 1/2^FRAC_W.
- RST_INT, SYS_FREQ/(16*BAUD_RATE): integer divisor at reset.
- RST_FRAC, round((SYS_FREQ mod (16*BAUD_RATE))*2^FRAC_W/(16*BAUD_RATE)): fractional divisor at reset.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count enable; when low, all counters hold and no tick is produced.
- sync_clr  in  1  one-cycle resynchronise pulse.
- cfg_we  in  1  loads the shadow configuration.
- cfg_int  in  DVSR_W  integer divisor; legal values are 2 or greater.
- cfg_frac  in  FRAC_W  fractional divisor.
- cfg_osr8  in  1  selects oversampling: 1 = 8x, 0 = 16x.
- cfg_err  out  1  one-cycle pulse when a write has cfg_int < 2; that write is discarded.
- cfg_pending  out  1  shadow configuration loaded but not yet applied.
- tick  out  1  oversample tick, one cycle wide.
- sample_tick  out  1  mid-bit tick, one cycle wide.
- bit_tick  out  1  bit-period tick, one cycle wide.

## Operation
- Active registers:
  - int_r and frac_r (reset to RST_INT and RST_FRAC);
  - osr8_r (reset 0);
  - down-counter cnt, DVSR_W+1 bits, reset to RST_INT-1;
  - fractional accumulator acc, FRAC_W bits, reset 0;
  - oversample counter os, 4 bits, reset 0.
- Shadow registers: sh_int, sh_frac, sh_osr8, and the pend flag.
- Counting, only while enable=1:
  - If cnt≠0: cnt decrements.
  - If cnt=0 (a reload edge), on that edge:
    - tick is registered to 1.
    - {carry, acc} = acc + frac_r, in FRAC_W+1 bits.
    - cnt = int_r - 1 + carry, so the next period is int_r + carry cycles.
    - os = (os+1) mod OSR, where OSR = 8 if osr8_r else 16.
- Outputs:
  - sample_tick is registered to 1 on the reload edge where the pre-increment os = OSR/2-1.
  - bit_tick is registered to 1 on the reload edge where the pre-increment os = OSR-1.
  - All three ticks are 0 on every other edge.
- Configuration:
  - cfg_we with cfg_int ≥ 2 writes the shadow registers and sets pend.
  - cfg_we with cfg_int < 2 pulses cfg_err on the next cycle and leaves shadow and pend unchanged.
  - cfg_pending = pend.
  - The shadow is applied, and pend cleared, at the first of:
    - a reload edge: the new int_r/frac_r/osr8_r govern the period that starts there, with cnt = sh_int-1, acc = 0 and os = 0;
    - a sync_clr;
    - any edge with enable=0.
- sync_clr:
  - Sets cnt = int_r-1 (using the shadow value if pend), acc = 0, os = 0.
  - No tick is produced on that edge, even if cnt=0.
  - Clears pend after applying the shadow.
- Priority: reset > sync_clr > cfg apply > normal counting.
- cfg_we in the same cycle as an apply edge: the old shadow is applied, the new write is captured, and pend stays 1.

## Timing
- All outputs are registered and are 0 during and immediately after reset.
- With enable held high from reset release, the first tick occurs at the RST_INT-th rising edge.
  - Tick-to-tick spacing is int_r or int_r+1 cycles.
  - Over 2^FRAC_W consecutive ticks, exactly frac_r periods are int_r+1 cycles long.
- Simultaneous ticks:
  - bit_tick coincides with the tick of the OSR-th period.
  - sample_tick coincides with the tick of the (OSR/2)-th period.
- After sync_clr at edge E, the next tick occurs at edge E+int_r.
- Deasserting enable freezes cnt, acc and os. Counting resumes where it stopped, with no lost or extra tick.
- cfg_err latency is 1 cycle.
- Reset asserted mid-period forces all state to reset values asynchronously. Any in-flight tick is dropped.

## Test plan
- Reset values, defaults (100 MHz, 9600 baud, FRAC_W=4; int 651, frac 1):
  - 16 consecutive tick periods measure fifteen of 651 cycles and one of 652.
  - Total 10417 cycles.
  - bit_tick on the 16th tick; sample_tick on the 8th tick.
- Configuration write:
  - Write cfg_int=4, cfg_frac=8, cfg_osr8=1 mid-period.
  - cfg_pending stays 1 until the next tick.
  - After the next tick, periods alternate 4 and 5 cycles, starting with 4.
  - bit_tick every 8 ticks (36 cycles); sample_tick on the 4th tick.
- Illegal configuration: write cfg_int=1.
  - cfg_err pulses 1 cycle later.
  - cfg_pending stays 0; tick spacing is unchanged.
- Resynchronisation:
  - Pulse sync_clr 3 cycles before an expected tick: that tick is suppressed.
  - The next tick arrives int_r cycles after sync_clr; os restarts, so bit_tick comes OSR ticks later.
- Enable gating: with cfg_int=10, drop enable for 7 cycles mid-period.
  - The tick is delayed by exactly 7 cycles.
  - No ticks occur while enable=0.
- Asynchronous reset: assert reset between clock edges mid-period.
  - All outputs go to 0 immediately; cfg_pending goes to 0.
  - After release, the first tick occurs at the 651st edge.
